// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : riscv_pkg                                                    |
// | Description : Shared RV32 definitions for the fetch stage and the decoder: |
// |               data width, canonical NOP, default reset PC, base opcodes,  |
// |               fetch request FSM state type and a word-align helper.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes (instr[6:0]) shared with the decoder.
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    // Request FSM: IDLE (no request), BUSY (request whose data will be kept),
    // DROP (request still outstanding whose data must be thrown away).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits of an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fetch_unit_if                                                |
// | Description : Instruction-memory req/ack bus plus the decode-side         |
// |               valid/ready/redirect bus of the fetch stage.                 |
// |   master (fetch unit) : drives imem_req, imem_addr, instr_valid, instr,   |
// |                         instr_pc; receives imem_ack, imem_rdata,          |
// |                         instr_ready, redirect, redirect_target            |
// |   slave (environment) : the mirror image                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : 2-entry FIFO of {instr, pc} with registered head outputs.   |
// |   clk, rst_n        : clock, asynchronous active-low reset                 |
// |   push_i, push_*_i  : write an entry (at the first free slot after pop)   |
// |   pop_i             : drop the head (caller guarantees head is valid)     |
// |   flush_i           : empty the queue; takes priority over push           |
// |   count_o           : current occupancy 0..2                               |
// |   head_*_o          : registered head valid / instruction / pc            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue
    import riscv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            push_i,
    input  wire logic [XLEN-1:0] push_instr_i,
    input  wire logic [XLEN-1:0] push_pc_i,
    input  wire logic            pop_i,
    input  wire logic            flush_i,
    output logic [1:0]           count_o,
    output logic                 head_valid_o,
    output logic [XLEN-1:0]      head_instr_o,
    output logic [XLEN-1:0]      head_pc_o
);

    logic [1:0]      count_q, count_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [XLEN-1:0] tail_instr_q, tail_instr_d;
    logic [XLEN-1:0] tail_pc_q, tail_pc_d;
    logic [1:0]      w_cnt_pop;

    always_comb begin
        w_cnt_pop    = count_q - {1'b0, pop_i};
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            // Shift first so the push lands behind whatever survives the pop.
            if (pop_i) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end
            if (push_i) begin
                if (w_cnt_pop == 2'd0) begin
                    head_instr_d = push_instr_i;
                    head_pc_d    = push_pc_i;
                end else begin
                    tail_instr_d = push_instr_i;
                    tail_pc_d    = push_pc_i;
                end
            end
            count_d = w_cnt_pop + {1'b0, push_i};
        end
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            valid_q      <= 1'b0;
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= '0;
            tail_instr_q <= NOP_INSTR;
            tail_pc_q    <= '0;
        end else begin
            count_q      <= count_d;
            valid_q      <= valid_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q;
    assign head_instr_o = head_instr_q;
    assign head_pc_o    = head_pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Keeps the PC, issues one word      |
// |               request at a time to instruction memory, queues returned    |
// |               words (2 deep) for decode and handles redirects.            |
// |   RESET_PC : fetch address after reset                                     |
// |   QDEPTH   : instruction queue depth (only 2 supported)                    |
// |   clk      : clock                                                         |
// |   rst_n    : asynchronous active-low reset                                 |
// |   bus      : fetch_unit_if.master - imem req/ack and decode valid/ready   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fetch_unit_if.master bus
);

    localparam logic [1:0] c_depth = 2'(QDEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic            w_pop;
    logic            w_redir;
    logic [XLEN-1:0] w_tgt;
    logic [1:0]      w_count;
    logic [1:0]      w_cnt_pop;
    logic            w_push;
    logic            w_head_valid;
    logic [XLEN-1:0] w_head_instr;
    logic [XLEN-1:0] w_head_pc;

    assign w_pop     = w_head_valid & bus.instr_ready;
    assign w_redir   = w_pop & bus.redirect;
    assign w_tgt     = word_align(bus.redirect_target);
    assign w_cnt_pop = w_count - {1'b0, w_pop};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        w_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_redir) begin
                    // Queue is flushed, so the target can be requested at once.
                    pc_d    = w_tgt;
                    req_d   = 1'b1;
                    addr_d  = w_tgt;
                    state_d = BUSY;
                end else if (w_cnt_pop < c_depth) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (w_redir) begin
                    pc_d = w_tgt;
                    if (bus.imem_ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Request must complete at the old address; its data is junk.
                        state_d = DROP;
                    end
                end else if (bus.imem_ack) begin
                    w_push = 1'b1;
                    pc_d   = addr_q + XLEN'(4);
                    // One outstanding request may only be issued into a free slot.
                    if (w_cnt_pop + 2'd1 < c_depth) begin
                        addr_d = addr_q + XLEN'(4);
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    fetch_queue u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (w_push),
        .push_instr_i (bus.imem_rdata),
        .push_pc_i    (addr_q),
        .pop_i        (w_pop),
        .flush_i      (w_redir),
        .count_o      (w_count),
        .head_valid_o (w_head_valid),
        .head_instr_o (w_head_instr),
        .head_pc_o    (w_head_pc)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = w_head_valid;
    assign bus.instr       = w_head_instr;
    assign bus.instr_pc    = w_head_pc;

endmodule
`default_nettype wire
